// File: rtl/eth_stats_pkg.sv
// Shared definitions for the Ethernet statistics accumulators (rx and tx).
// Holds the counter width, the counter slot indices and the four-counter
// record used for both the live and the snapshot views.
package eth_stats_pkg;

  localparam int STATS_CNT_W  = 64;
  localparam int NUM_CNT      = 4;
  localparam int FRAME_BYTES_W = 16;
  // frame_bytes + 1 needs one extra bit so 16'hFFFF becomes 65536
  localparam int FRAME_LEN_W  = FRAME_BYTES_W + 1;

  // Slot of each counter inside the counter array
  typedef enum logic [1:0] {
    CNT_TOTAL_BYTES = 2'd0,
    CNT_GOOD_BYTES  = 2'd1,
    CNT_GOOD_FRAMES = 2'd2,
    CNT_BAD_FRAMES  = 2'd3
  } cnt_idx_e;

  typedef struct packed {
    logic [STATS_CNT_W-1:0] total_bytes;
    logic [STATS_CNT_W-1:0] good_bytes;
    logic [STATS_CNT_W-1:0] good_frames;
    logic [STATS_CNT_W-1:0] bad_frames;
  } eth_stats_t;

  // Real frame length from the "length minus one" field, zero-extended
  function automatic logic [STATS_CNT_W-1:0] frame_len(
    input logic [FRAME_BYTES_W-1:0] frame_bytes
  );
    logic [FRAME_LEN_W-1:0] len;
    len = {1'b0, frame_bytes} + {{(FRAME_LEN_W-1){1'b0}}, 1'b1};
    return {{(STATS_CNT_W-FRAME_LEN_W){1'b0}}, len};
  endfunction

endpackage

// File: rtl/eth_stats_acc_counter.sv
// Single wrapping accumulator. count_next is the value the register will
// take on the coming edge unless it is cleared or reset, so a snapshot can
// capture an event arriving in the same cycle as the request.
module eth_stats_acc_counter #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         add_en,
  input  logic [W-1:0] add_val,
  input  logic         clear,
  output logic [W-1:0] count_next
);

  logic [W-1:0] count_reg;

  // Next value: add when enabled, natural modulo-2^W wrap
  always_comb begin
    count_next = count_reg;
    if (add_en) begin
      count_next = count_reg + add_val;
    end
  end

  // Counter register: reset and clear both win over the accumulated value
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/eth_stats_accumulator_rx.sv
// Receive-side statistics accumulator. Counts bytes and frames per completed
// frame event and publishes a coherent snapshot of all four counters on
// request, optionally zeroing the live counters at the same time.
module eth_stats_accumulator_rx
  import eth_stats_pkg::*;
#(
  parameter bit CLEAR_ON_SNAP = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [FRAME_BYTES_W-1:0] frame_bytes,
  input  logic                     frame_good,
  input  logic                     valid,
  input  logic                     snap_req,
  output logic                     snap_ack,
  output logic [STATS_CNT_W-1:0]   snap_total_bytes,
  output logic [STATS_CNT_W-1:0]   snap_good_bytes,
  output logic [STATS_CNT_W-1:0]   snap_good_frames,
  output logic [STATS_CNT_W-1:0]   snap_bad_frames
);

  logic                                frame_evt;
  logic [STATS_CNT_W-1:0]              frame_len_val;
  logic                                clear_live;
  logic [NUM_CNT-1:0]                  add_en;
  logic [NUM_CNT-1:0][STATS_CNT_W-1:0] add_val;
  logic [NUM_CNT-1:0][STATS_CNT_W-1:0] cnt_next;
  eth_stats_t                          live_next;
  eth_stats_t                          snap_reg;
  logic                                snap_ack_reg;

  assign frame_evt     = valid & enable;
  assign frame_len_val = frame_len(frame_bytes);
  // Clearing happens on the same edge that captures the snapshot, so an
  // event in the request cycle lands in the snapshot but not in live state
  assign clear_live    = snap_req & CLEAR_ON_SNAP;

  // Route each frame event to the counters it affects
  always_comb begin
    add_en  = '0;
    add_val = '0;
    add_en[CNT_TOTAL_BYTES]  = frame_evt;
    add_val[CNT_TOTAL_BYTES] = frame_len_val;
    add_en[CNT_GOOD_BYTES]   = frame_evt & frame_good;
    add_val[CNT_GOOD_BYTES]  = frame_len_val;
    add_en[CNT_GOOD_FRAMES]  = frame_evt & frame_good;
    add_val[CNT_GOOD_FRAMES] = {{(STATS_CNT_W-1){1'b0}}, 1'b1};
    add_en[CNT_BAD_FRAMES]   = frame_evt & ~frame_good;
    add_val[CNT_BAD_FRAMES]  = {{(STATS_CNT_W-1){1'b0}}, 1'b1};
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
      eth_stats_acc_counter #(
        .W (STATS_CNT_W)
      ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .add_en     (add_en[gi]),
        .add_val    (add_val[gi]),
        .clear      (clear_live),
        .count_next (cnt_next[gi])
      );
    end
  endgenerate

  // Gather the post-edge counter values into one record
  always_comb begin
    live_next             = '0;
    live_next.total_bytes = cnt_next[CNT_TOTAL_BYTES];
    live_next.good_bytes  = cnt_next[CNT_GOOD_BYTES];
    live_next.good_frames = cnt_next[CNT_GOOD_FRAMES];
    live_next.bad_frames  = cnt_next[CNT_BAD_FRAMES];
  end

  // Snapshot register and acknowledge; reset suppresses any pending request
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_reg     <= '0;
      snap_ack_reg <= 1'b0;
    end else begin
      snap_ack_reg <= snap_req;
      if (snap_req) begin
        snap_reg <= live_next;
      end
    end
  end

  assign snap_ack         = snap_ack_reg;
  assign snap_total_bytes = snap_reg.total_bytes;
  assign snap_good_bytes  = snap_reg.good_bytes;
  assign snap_good_frames = snap_reg.good_frames;
  assign snap_bad_frames  = snap_reg.bad_frames;

endmodule

// File: tb/tb_eth_stats_accumulator_rx.sv
// Directed bench for eth_stats_accumulator_rx. Instance a keeps live counters
// across snapshots, instance c clears them at every snapshot; both share
// the same stimulus. Inputs change on the falling edge, outputs are sampled
// on the following falling edge.
module tb_eth_stats_accumulator_rx;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [15:0] frame_bytes;
  logic        frame_good;
  logic        valid;
  logic        snap_req;

  logic        a_ack, c_ack;
  logic [63:0] a_total, a_gbytes, a_gframes, a_bframes;
  logic [63:0] c_total, c_gbytes, c_gframes, c_bframes;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  eth_stats_accumulator_rx #(.CLEAR_ON_SNAP(1'b0)) dut_a (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .frame_bytes      (frame_bytes),
    .frame_good       (frame_good),
    .valid            (valid),
    .snap_req         (snap_req),
    .snap_ack         (a_ack),
    .snap_total_bytes (a_total),
    .snap_good_bytes  (a_gbytes),
    .snap_good_frames (a_gframes),
    .snap_bad_frames  (a_bframes)
  );

  eth_stats_accumulator_rx #(.CLEAR_ON_SNAP(1'b1)) dut_c (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .frame_bytes      (frame_bytes),
    .frame_good       (frame_good),
    .valid            (valid),
    .snap_req         (snap_req),
    .snap_ack         (c_ack),
    .snap_total_bytes (c_total),
    .snap_good_bytes  (c_gbytes),
    .snap_good_frames (c_gframes),
    .snap_bad_frames  (c_bframes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    valid    = 1'b0;
    snap_req = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; valid = 1'b1; snap_req = 1'b1;
    frame_bytes = 16'd50; frame_good = 1'b1;
    step(); step();
    $display("reset: ack=%0b total=%0d", a_ack, a_total);
    chk_cnt++; if (a_ack !== 1'b0) $display("FAIL reset_ack got %0b exp 0", a_ack); else pass_cnt++;
    chk_cnt++; if (a_total !== 64'd0) $display("FAIL reset_total got %0d exp 0", a_total); else pass_cnt++;
    chk_cnt++; if (a_gbytes !== 64'd0) $display("FAIL reset_gbytes got %0d exp 0", a_gbytes); else pass_cnt++;
    chk_cnt++; if (a_gframes !== 64'd0) $display("FAIL reset_gframes got %0d exp 0", a_gframes); else pass_cnt++;
    chk_cnt++; if (a_bframes !== 64'd0) $display("FAIL reset_bframes got %0d exp 0", a_bframes); else pass_cnt++;
    rst = 1'b0;
    idle();
  endtask

  task automatic test_single_frame();
    valid = 1'b1; frame_bytes = 16'd63; frame_good = 1'b1;
    step();
    valid = 1'b0; snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    $display("single: ack=%0b total=%0d gb=%0d gf=%0d bf=%0d", a_ack, a_total, a_gbytes, a_gframes, a_bframes);
    chk_cnt++; if (a_ack !== 1'b1) $display("FAIL single_ack got %0b exp 1", a_ack); else pass_cnt++;
    chk_cnt++; if (a_total !== 64'd64) $display("FAIL single_total got %0d exp 64", a_total); else pass_cnt++;
    chk_cnt++; if (a_gbytes !== 64'd64) $display("FAIL single_gbytes got %0d exp 64", a_gbytes); else pass_cnt++;
    chk_cnt++; if (a_gframes !== 64'd1) $display("FAIL single_gframes got %0d exp 1", a_gframes); else pass_cnt++;
    chk_cnt++; if (a_bframes !== 64'd0) $display("FAIL single_bframes got %0d exp 0", a_bframes); else pass_cnt++;
    // a frame with no request must not move the held snapshot
    valid = 1'b1; frame_bytes = 16'd7;
    step();
    valid = 1'b0;
    chk_cnt++; if (a_ack !== 1'b0) $display("FAIL single_ack_drop got %0b exp 0", a_ack); else pass_cnt++;
    chk_cnt++; if (a_total !== 64'd64) $display("FAIL single_hold got %0d exp 64", a_total); else pass_cnt++;
  endtask

  task automatic test_three_frames();
    do_reset();
    // lengths 100 (good) + 1500 (bad) + 1 (good)
    valid = 1'b1;
    frame_bytes = 16'd99;   frame_good = 1'b1; step();
    frame_bytes = 16'd1499; frame_good = 1'b0; step();
    frame_bytes = 16'd0;    frame_good = 1'b1; step();
    valid = 1'b0; snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    $display("three: total=%0d gb=%0d gf=%0d bf=%0d", a_total, a_gbytes, a_gframes, a_bframes);
    chk_cnt++; if (a_total !== 64'd1601) $display("FAIL three_total got %0d exp 1601", a_total); else pass_cnt++;
    chk_cnt++; if (a_gbytes !== 64'd101) $display("FAIL three_gbytes got %0d exp 101", a_gbytes); else pass_cnt++;
    chk_cnt++; if (a_gframes !== 64'd2) $display("FAIL three_gframes got %0d exp 2", a_gframes); else pass_cnt++;
    chk_cnt++; if (a_bframes !== 64'd1) $display("FAIL three_bframes got %0d exp 1", a_bframes); else pass_cnt++;
  endtask

  task automatic test_enable();
    do_reset();
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      valid = 1'b1; frame_bytes = 16'(100 * i + 3); frame_good = i[0];
      step();
    end
    enable = 1'b1; valid = 1'b0; snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    $display("disabled: total=%0d gb=%0d gf=%0d bf=%0d", a_total, a_gbytes, a_gframes, a_bframes);
    chk_cnt++; if (a_total !== 64'd0) $display("FAIL dis_total got %0d exp 0", a_total); else pass_cnt++;
    chk_cnt++; if (a_gbytes !== 64'd0) $display("FAIL dis_gbytes got %0d exp 0", a_gbytes); else pass_cnt++;
    chk_cnt++; if (a_gframes !== 64'd0) $display("FAIL dis_gframes got %0d exp 0", a_gframes); else pass_cnt++;
    chk_cnt++; if (a_bframes !== 64'd0) $display("FAIL dis_bframes got %0d exp 0", a_bframes); else pass_cnt++;
    // maximum length field: 16'hFFFF means 65536 bytes
    valid = 1'b1; frame_bytes = 16'hFFFF; frame_good = 1'b1;
    step();
    valid = 1'b0; snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    $display("maxlen: total=%0d gb=%0d", a_total, a_gbytes);
    chk_cnt++; if (a_total !== 64'd65536) $display("FAIL max_total got %0d exp 65536", a_total); else pass_cnt++;
    chk_cnt++; if (a_gbytes !== 64'd65536) $display("FAIL max_gbytes got %0d exp 65536", a_gbytes); else pass_cnt++;
    chk_cnt++; if (a_gframes !== 64'd1) $display("FAIL max_gframes got %0d exp 1", a_gframes); else pass_cnt++;
  endtask

  task automatic test_clear_on_snap();
    do_reset();
    valid = 1'b1; frame_bytes = 16'd9; frame_good = 1'b1; snap_req = 1'b1;
    step();
    valid = 1'b0;
    $display("clr snap1: c_total=%0d a_total=%0d", c_total, a_total);
    chk_cnt++; if (c_ack !== 1'b1) $display("FAIL clr1_ack got %0b exp 1", c_ack); else pass_cnt++;
    chk_cnt++; if (c_total !== 64'd10) $display("FAIL clr1_total got %0d exp 10", c_total); else pass_cnt++;
    chk_cnt++; if (c_gframes !== 64'd1) $display("FAIL clr1_gframes got %0d exp 1", c_gframes); else pass_cnt++;
    chk_cnt++; if (a_total !== 64'd10) $display("FAIL keep1_total got %0d exp 10", a_total); else pass_cnt++;
    step();  // second back-to-back request, no frame
    snap_req = 1'b0;
    $display("clr snap2: c_total=%0d a_total=%0d", c_total, a_total);
    chk_cnt++; if (c_ack !== 1'b1) $display("FAIL clr2_ack got %0b exp 1", c_ack); else pass_cnt++;
    chk_cnt++; if (c_total !== 64'd0) $display("FAIL clr2_total got %0d exp 0", c_total); else pass_cnt++;
    chk_cnt++; if (c_gbytes !== 64'd0) $display("FAIL clr2_gbytes got %0d exp 0", c_gbytes); else pass_cnt++;
    chk_cnt++; if (c_gframes !== 64'd0) $display("FAIL clr2_gframes got %0d exp 0", c_gframes); else pass_cnt++;
    chk_cnt++; if (c_bframes !== 64'd0) $display("FAIL clr2_bframes got %0d exp 0", c_bframes); else pass_cnt++;
    chk_cnt++; if (a_total !== 64'd10) $display("FAIL keep2_total got %0d exp 10", a_total); else pass_cnt++;
    // bad frame of length 5 after the clear
    valid = 1'b1; frame_bytes = 16'd4; frame_good = 1'b0; snap_req = 1'b1;
    step();
    idle();
    chk_cnt++; if (c_total !== 64'd5) $display("FAIL clr3_total got %0d exp 5", c_total); else pass_cnt++;
    chk_cnt++; if (c_bframes !== 64'd1) $display("FAIL clr3_bframes got %0d exp 1", c_bframes); else pass_cnt++;
    chk_cnt++; if (a_total !== 64'd15) $display("FAIL keep3_total got %0d exp 15", a_total); else pass_cnt++;
    chk_cnt++; if (a_gframes !== 64'd1) $display("FAIL keep3_gframes got %0d exp 1", a_gframes); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    // frames every cycle with lengths 1,2,3,4; requests in the last two
    for (int i = 0; i < 4; i++) begin
      valid = 1'b1; frame_bytes = 16'(i); frame_good = 1'b1;
      snap_req = (i >= 2);
      step();
      if (i == 2) begin
        chk_cnt++; if (a_ack !== 1'b1) $display("FAIL b2b_ack1 got %0b exp 1", a_ack); else pass_cnt++;
        chk_cnt++; if (a_total !== 64'd6) $display("FAIL b2b_total1 got %0d exp 6", a_total); else pass_cnt++;
      end
      if (i == 3) begin
        chk_cnt++; if (a_ack !== 1'b1) $display("FAIL b2b_ack2 got %0b exp 1", a_ack); else pass_cnt++;
        chk_cnt++; if (a_total !== 64'd10) $display("FAIL b2b_total2 got %0d exp 10", a_total); else pass_cnt++;
        chk_cnt++; if (a_gframes !== 64'd4) $display("FAIL b2b_gframes got %0d exp 4", a_gframes); else pass_cnt++;
      end
    end
    idle();
    step();
    $display("b2b: total=%0d ack=%0b", a_total, a_ack);
    chk_cnt++; if (a_ack !== 1'b0) $display("FAIL b2b_ack_end got %0b exp 0", a_ack); else pass_cnt++;
  endtask

  task automatic test_wrap();
    do_reset();
    // live total preloaded to 2^64-10; a 20-byte frame wraps it to 10
    force dut_a.g_cnt[0].u_cnt.count_reg = 64'hFFFF_FFFF_FFFF_FFF6;
    valid = 1'b1; frame_bytes = 16'd19; frame_good = 1'b1; snap_req = 1'b1;
    step();
    idle();
    release dut_a.g_cnt[0].u_cnt.count_reg;
    $display("wrap: total=%0d gb=%0d", a_total, a_gbytes);
    chk_cnt++; if (a_total !== 64'd10) $display("FAIL wrap_total got %0d exp 10", a_total); else pass_cnt++;
    chk_cnt++; if (a_gbytes !== 64'd20) $display("FAIL wrap_gbytes got %0d exp 20", a_gbytes); else pass_cnt++;
    do_reset();
  endtask

  task automatic test_reset_override();
    do_reset();
    valid = 1'b1; frame_bytes = 16'd7; frame_good = 1'b1; snap_req = 1'b1;
    step();
    chk_cnt++; if (a_total !== 64'd8) $display("FAIL pre_rst_total got %0d exp 8", a_total); else pass_cnt++;
    rst = 1'b1; valid = 1'b1; frame_bytes = 16'd5; snap_req = 1'b1;
    step();
    rst = 1'b0; idle();
    $display("rst override: ack=%0b total=%0d", a_ack, a_total);
    chk_cnt++; if (a_ack !== 1'b0) $display("FAIL rstov_ack got %0b exp 0", a_ack); else pass_cnt++;
    chk_cnt++; if (a_total !== 64'd0) $display("FAIL rstov_total got %0d exp 0", a_total); else pass_cnt++;
    chk_cnt++; if (a_gframes !== 64'd0) $display("FAIL rstov_gframes got %0d exp 0", a_gframes); else pass_cnt++;
    chk_cnt++; if (c_total !== 64'd0) $display("FAIL rstov_c_total got %0d exp 0", c_total); else pass_cnt++;
    step();
    chk_cnt++; if (a_ack !== 1'b0) $display("FAIL rstov_late_ack got %0b exp 0", a_ack); else pass_cnt++;
    // first cycle after reset: event and request handled normally
    valid = 1'b1; frame_bytes = 16'd4; frame_good = 1'b1; snap_req = 1'b1;
    step();
    idle();
    $display("post rst: ack=%0b total=%0d", a_ack, a_total);
    chk_cnt++; if (a_ack !== 1'b1) $display("FAIL post_rst_ack got %0b exp 1", a_ack); else pass_cnt++;
    chk_cnt++; if (a_total !== 64'd5) $display("FAIL post_rst_total got %0d exp 5", a_total); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; valid = 1'b0; snap_req = 1'b0;
    frame_bytes = 16'd0; frame_good = 1'b0;
    test_reset();
    test_single_frame();
    test_three_frames();
    test_enable();
    test_clear_on_snap();
    test_back_to_back();
    test_wrap();
    test_reset_override();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
